// File: rtl/adder_meas_pkg.sv
// Shared types and default sizing for the adder ring-oscillator measurement stage.
package adder_meas_pkg;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WIN_W         = 24;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Observation bundle: FSM state plus the synchronised ring level.
  typedef struct packed {
    state_t state;
    logic   chain_level;
  } dbg_t;

endpackage

// File: rtl/adder_ring_meas_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous bit followed by a rising-edge detector.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/adder_ring_meas.sv
// Enables the adder ring oscillator and counts its rising edges over a programmable window.
// Handshake: start is a single-cycle request honoured only in IDLE; done is a one-cycle result-valid pulse.
module adder_ring_meas
  import adder_meas_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WIN_W         = DEF_WIN_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [WIN_W-1:0] window_cycles,
  input  logic             chain_out,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output dbg_t             dbg
);

  state_t           state, state_next;
  logic [WIN_W-1:0] win_q, win_next;
  logic [WIN_W-1:0] tmr_q, tmr_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next;
  logic             chain_level;
  logic             rise;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .din   (chain_out),
    .level (chain_level),
    .rise  (rise)
  );

  // One down-counter serves both the settle delay and the measurement window.
  always_comb begin
    state_next = state;
    win_next   = win_q;
    tmr_next   = tmr_q;
    count_next = count;
    ovf_next   = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          count_next = '0;
          ovf_next   = 1'b0;
          if (window_cycles != '0) begin
            win_next   = window_cycles;
            tmr_next   = WIN_W'(SETTLE_CYCLES - 1);
            state_next = SETTLE;
          end else begin
            state_next = DONE;
          end
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          tmr_next   = win_q - WIN_W'(1);
          state_next = RUN;
        end else begin
          tmr_next = tmr_q - WIN_W'(1);
        end
      end
      RUN: begin
        if (rise) begin
          if (count == '1) ovf_next = 1'b1;
          else             count_next = count + CNT_W'(1);
        end
        if (tmr_q == '0) state_next = DONE;
        else             tmr_next   = tmr_q - WIN_W'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so ring_en cannot glitch.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      win_q    <= '0;
      tmr_q    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ring_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      win_q    <= win_next;
      tmr_q    <= tmr_next;
      count    <= count_next;
      overflow <= ovf_next;
      ring_en  <= (state_next == SETTLE) || (state_next == RUN);
      busy     <= (state_next == SETTLE) || (state_next == RUN);
      done     <= (state_next == DONE);
    end
  end

  assign dbg.state       = state;
  assign dbg.chain_level = chain_level;

endmodule

// File: tb/tb_adder_ring_meas.sv
// Bench for adder_ring_meas: vector table, hand-written corner sequences and random windows vs a sample-history model.
module tb_adder_ring_meas;
  import adder_meas_pkg::*;

  localparam int CNT_W = 10;
  localparam int WIN_W = 16;
  localparam int SYNC  = 2;
  localparam int S     = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIN_W-1:0] window_cycles;
  logic             chain_out = 1'b0;
  logic             ring_en, busy, done, overflow;
  logic [CNT_W-1:0] count;
  dbg_t             dbg;

  adder_ring_meas #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC), .SETTLE_CYCLES(S)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .start         (start),
    .window_cycles (window_cycles),
    .chain_out     (chain_out),
    .ring_en       (ring_en),
    .busy          (busy),
    .done          (done),
    .count         (count),
    .overflow      (overflow),
    .dbg           (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- ring stimulus and sample history ----------------
  int mode = 0;  // 0 static, 1 square wave with half period hp, 2 random
  int hp   = 1;
  int ph   = 0;
  int cyc  = 0;
  bit hist[$];

  always @(negedge clk) begin
    case (mode)
      1: begin
        ph++;
        if (ph >= hp) begin
          ph = 0;
          chain_out = ~chain_out;
        end
      end
      2:       chain_out = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  always @(posedge clk) begin
    cyc++;
    hist.push_back(chain_out);
  end

  function automatic bit x(int k);
    return hist[k-1];
  endfunction

  // Rising transitions seen by the counter: samples pass SYNC flops before the edge compare.
  function automatic int model_edges(int c, int w);
    int n = 0;
    for (int k = c + S + 1; k <= c + S + w; k++)
      if (x(k - SYNC + 1) && !x(k - SYNC)) n++;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic measure(input int w, output int c, output logic [CNT_W-1:0] cnt_first,
                         output logic [CNT_W-1:0] cnt_o, output logic ovf_o);
    int de;
    bit ok;
    ok = 1;
    @(negedge clk);
    start = 1'b1;
    window_cycles = WIN_W'(w);
    c = cyc;
    @(negedge clk);
    start = 1'b0;
    window_cycles = WIN_W'($urandom);
    cnt_first = count;
    de = (w == 0) ? c + 1 : c + 1 + S + w;
    for (int i = 0; i <= S + w + 1; i++) begin
      if (ring_en !== ((w != 0) && (cyc <= c + S + w))) ok = 0;
      if (busy !== ((w != 0) && (cyc <= c + S + w))) ok = 0;
      if (done !== (cyc == de)) ok = 0;
      if (cyc == de) break;
      @(negedge clk);
    end
    check($sformatf("timing_w%0d", w), int'(ok && (cyc == de)), 1);
    cnt_o = count;
    ovf_o = overflow;
  endtask

  typedef struct {
    int w;
    int hp;       // 0 = static ring
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c, ndone, dcyc;
    logic [CNT_W-1:0] cf, cnt;
    logic ovf;

    vecs[0] = '{64,   4, 8,    1'b0};
    vecs[1] = '{0,    4, 0,    1'b0};
    vecs[2] = '{40,   2, 10,   1'b0};
    vecs[3] = '{10,   1, 5,    1'b0};
    vecs[4] = '{2046, 1, CMAX, 1'b0};
    vecs[5] = '{2048, 1, CMAX, 1'b1};
    vecs[6] = '{4096, 1, CMAX, 1'b1};
    vecs[7] = '{50,   0, 0,    1'b0};

    rst = 1'b1;
    start = 1'b0;
    window_cycles = '0;
    repeat (3) @(negedge clk);
    check("rst_ring_en", ring_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg.state, IDLE);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Vector table: square-wave rings give exact edge counts whatever the phase.
    foreach (vecs[i]) begin
      mode = (vecs[i].hp == 0) ? 0 : 1;
      hp = (vecs[i].hp == 0) ? 1 : vecs[i].hp;
      measure(vecs[i].w, c, cf, cnt, ovf);
      check($sformatf("vec%0d_first_count", i), cf, 0);
      check($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_overflow", i), ovf, vecs[i].exp_ovf);
      repeat (3) @(negedge clk);
    end

    // Hold after done, then clear on the next accepted start.
    mode = 1; hp = 4;
    measure(64, c, cf, cnt, ovf);
    check("hold_base_count", cnt, 8);
    begin
      bit held = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (count !== 8 || done !== 1'b0 || ring_en !== 1'b0) held = 0;
      end
      check("hold_100_cycles", held, 1);
    end
    mode = 0;
    measure(30, c, cf, cnt, ovf);
    check("clear_at_t1", cf, 0);
    check("clear_final", cnt, 0);

    // Reset in the middle of RUN.
    mode = 1; hp = 1;
    @(negedge clk);
    start = 1'b1; window_cycles = WIN_W'(200);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("midrun_count_nonzero", int'(count != 0), 1);
    check("midrun_state_run", dbg.state, RUN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_ring_en", ring_en, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_count", count, 0);
    check("midrun_rst_overflow", overflow, 0);
    check("midrun_rst_state", dbg.state, IDLE);
    repeat (5) @(negedge clk);
    check("midrun_no_done", done, 0);
    measure(20, c, cf, cnt, ovf);
    check("after_rst_count", cnt, 10);

    // Start pulses during RUN and during the DONE cycle are ignored.
    mode = 1; hp = 4;
    @(negedge clk);
    start = 1'b1; window_cycles = WIN_W'(64);
    c = cyc;
    @(negedge clk);
    start = 1'b0; window_cycles = WIN_W'(3);
    repeat (S + 10) @(negedge clk);
    start = 1'b1; window_cycles = WIN_W'(5);
    @(negedge clk);
    start = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        dcyc = cyc;
        cnt = count;
        start = 1'b1; window_cycles = WIN_W'(7);
        break;
      end
      @(negedge clk);
    end
    check("busy_start_done_cycle", dcyc, c + 1 + S + 64);
    check("busy_start_count", cnt, 8);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || ring_en === 1'b1) ndone++;
      @(negedge clk);
    end
    check("busy_start_ignored", ndone, 0);

    // Random windows against the sample-history model.
    for (int it = 0; it < 12; it++) begin
      int w, n;
      mode = (it % 2 == 0) ? 2 : 1;
      hp = $urandom_range(1, 5);
      w = $urandom_range(1, 300);
      measure(w, c, cf, cnt, ovf);
      n = model_edges(c, w);
      exp_q.push_back(CNT_W'((n > CMAX) ? CMAX : n));
      check($sformatf("rand%0d_count", it), cnt, exp_q.pop_front());
      check($sformatf("rand%0d_overflow", it), ovf, int'(n > CMAX));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_ring_meas.md
Name: adder_ring_meas

Overview:
Measurement stage directly downstream of the instrumented Sklansky adder. It enables the adder's ring-oscillator chain and counts rising edges of chain_out over a programmable window of wb_clk_i cycles. The count, a done pulse and an overflow flag are reported to the logic-analyser register bank. Firmware derives the adder propagation delay from count / window.

Parameters:
CNT_W, 16, width of edge counter / count output
WIN_W, 24, width of window length
SYNC_STAGES, 2, flops in chain_out synchroniser (min 2)
SETTLE_CYCLES, 4, cycles ring runs uncounted before window opens (>= SYNC_STAGES+1)

Ports:
wb_clk_i  in  1  system clock; only clock in block
wb_rst_i  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a measurement
window_cycles  in  WIN_W  window length in clocks; sampled when start is accepted
chain_out  in  1  ring-oscillator output from instrumented adder; asynchronous to wb_clk_i
ring_en  out  1  enables ring chain in the adder
busy  out  1  high while a measurement is in progress (SETTLE or RUN)
done  out  1  one-cycle pulse when result valid
count  out  CNT_W  rising edges counted in last window; saturating
overflow  out  1  set if count saturated in last window

Behaviour:
- Reset (sync, active-high, any state incl. mid-measurement): state=IDLE; ring_en=0, busy=0, done=0, count=0, overflow=0; synchroniser and edge-detect flops cleared; window latch=0.
- chain_out -> SYNC_STAGES-flop synchroniser -> one-flop edge detector; edge = sync_last & ~prev. Edges at rate > fclk/2 are undercounted by design (firmware divides ring chain accordingly).
- FSM states IDLE, SETTLE, RUN, DONE:
  - IDLE: ring_en=0. start=1 and window_cycles!=0 -> latch window, clear count/overflow, go SETTLE next cycle. start=1 and window_cycles==0 -> go DONE with count=0, overflow=0 (no ring enable).
  - SETTLE: ring_en=1, busy=1, edges ignored; stays exactly SETTLE_CYCLES cycles -> RUN.
  - RUN: ring_en=1, busy=1; each cycle with edge=1 increments count; stays exactly latched-window cycles -> DONE.
  - DONE: ring_en=0, busy=0, done=1 for this single cycle -> IDLE.
- Latency: start accepted at cycle T -> done high at T+1+SETTLE_CYCLES+W (W = window_cycles, non-zero); W=0 -> done at T+1.
- count/overflow hold from DONE until the next accepted start (cleared on entry to SETTLE/zero-window DONE).
- Saturation: count at 2^CNT_W-1 with another edge -> count holds, overflow=1 (sticky for that measurement).
- start while not IDLE (SETTLE/RUN/DONE) ignored; window_cycles changes after acceptance have no effect.
- Window counter is WIN_W wide, decrements from latched W; no wrap.
- ring_en is a registered output (no glitch into ring chain).

Decomposition:
- Package adder_meas_pkg: state enum (IDLE, SETTLE, RUN, DONE), default widths CNT_W/WIN_W/SYNC_STAGES/SETTLE_CYCLES as localparams.
- One sub-module: sync_edge_detect (param STAGES; in async bit, out synchronised level and rising-edge pulse, sync reset).

Test Plan:
- Reset mid-RUN: assert wb_rst_i during RUN -> next cycle ring_en=0, busy=0, count=0, overflow=0, state IDLE; later start works normally.
- Basic count: chain_out toggling every 4 clocks (period 8), start with W=64 -> done at T+69, count=8, overflow=0, ring_en high T+1..T+68.
- Zero window: start with W=0 -> done at T+1, count=0, ring_en never high.
- Saturation: chain_out toggling every clock (period 2), W=131072 -> count=0xFFFF, overflow=1.
- Start while busy: second start pulse during RUN and during DONE cycle -> ignored; only one done; count matches first measurement.
- Hold/clear: after done, count holds 8 for 100 idle cycles; new start with chain_out static -> count cleared to 0 at T+1, final count=0.
